// File: rtl/edge_sync_pkg.sv
// ---------------------------------------------------------------------------
// edge_sync_pkg
// Shared types and helpers for the edge_pulse_array block.
//   edge_mode_t : per-channel edge selection (rising / falling / both / off)
//   max_int     : elaboration-time maximum, used to size counters
// ---------------------------------------------------------------------------
package edge_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_BOTH    = 2'd2,
    EDGE_OFF     = 2'd3
  } edge_mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// ---------------------------------------------------------------------------
// edge_pulse_channel
// One channel: synchroniser -> optional glitch filter -> edge qualifier ->
// pulse stretcher, plus sticky event/overrun flags.
// Ports:
//   clk_i       : clock
//   reset_n_i   : synchronous active-low reset, clears every flop
//   signal_i    : asynchronous input
//   edge_mode_i : which edge(s) qualify
//   event_clr_i : clears event_o and overrun_o (a same-cycle set wins)
//   pulse_o     : PulseWidth-cycle pulse per qualified edge
//   event_o     : sticky, a qualified edge was seen
//   overrun_o   : sticky, a qualified edge arrived while pulse_o was high
// ---------------------------------------------------------------------------
module edge_pulse_channel
  import edge_sync_pkg::*;
#(
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 0,
  parameter int PulseWidth   = 1,
  parameter int Retrigger    = 1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       signal_i,
  input  edge_mode_t edge_mode_i,
  input  logic       event_clr_i,
  output logic       pulse_o,
  output logic       event_o,
  output logic       overrun_o
);

  localparam int FcWidth = max_int(1, $clog2(FilterCycles + 1));
  localparam int PcWidth = max_int(1, $clog2(PulseWidth));
  // A level change is accepted once it has differed from f for this many
  // consecutive cycles; FilterCycles=0 degenerates to a single register.
  localparam logic [FcWidth-1:0] FcLast = FcWidth'(max_int(FilterCycles, 1) - 1);
  localparam logic [PcWidth-1:0] PcLoad = PcWidth'(PulseWidth - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sync_s;
  logic                  f;
  logic                  f_d;
  logic [FcWidth-1:0]    fc;
  logic [PcWidth-1:0]    pc;
  logic                  edge_hit;

  assign sync_s = sync_q[SyncStages-1];

  // Synchroniser, filter and previous-level register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
      f      <= 1'b0;
      f_d    <= 1'b0;
      fc     <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], signal_i};
      f_d    <= f;
      if (sync_s != f) begin
        if (fc == FcLast) begin
          f  <= sync_s;
          fc <= '0;
        end else begin
          fc <= fc + FcWidth'(1);
        end
      end else begin
        fc <= '0;
      end
    end
  end

  // Edge qualification; the mode is looked at in the same cycle as the edge.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    edge_hit = 1'b0;
    case (edge_mode_i)
      EDGE_RISING:  edge_hit = ~f_d & f;
      EDGE_FALLING: edge_hit = f_d & ~f;
      EDGE_BOTH:    edge_hit = f ^ f_d;
      default:      edge_hit = 1'b0;
    endcase
  end

  // Pulse stretcher: pc counts the cycles left after the current one.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pulse_o <= 1'b0;
      pc      <= '0;
    end else if (!pulse_o) begin
      if (edge_hit) begin
        pulse_o <= 1'b1;
        pc      <= PcLoad;
      end
    end else if (edge_hit && (Retrigger != 0)) begin
      pc <= PcLoad;
    end else if (pc == '0) begin
      pulse_o <= 1'b0;
    end else begin
      pc <= pc - PcWidth'(1);
    end
  end

  // Sticky flags: set has priority over clear.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      event_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (edge_hit) begin
        event_o <= 1'b1;
      end else if (event_clr_i) begin
        event_o <= 1'b0;
      end
      if (edge_hit && pulse_o) begin
        overrun_o <= 1'b1;
      end else if (event_clr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/edge_pulse_array.sv
// ---------------------------------------------------------------------------
// edge_pulse_array
// Channels independent edge detectors with pulse stretching and sticky flags.
// Ports:
//   clk_i       : clock
//   reset_n_i   : synchronous active-low reset
//   signal_i    : [Channels] asynchronous inputs
//   edge_mode_i : [2*Channels] edge_mode_t per channel, channel n at [2n+1:2n]
//   event_clr_i : [Channels] clear of event_o/overrun_o
//   pulse_o     : [Channels] stretched pulses
//   event_o     : [Channels] sticky qualified-edge flags
//   overrun_o   : [Channels] sticky edge-during-pulse flags
// ---------------------------------------------------------------------------
module edge_pulse_array
  import edge_sync_pkg::*;
#(
  parameter int Channels     = 4,
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 0,
  parameter int PulseWidth   = 1,
  parameter int Retrigger    = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [Channels-1:0]   signal_i,
  input  logic [2*Channels-1:0] edge_mode_i,
  input  logic [Channels-1:0]   event_clr_i,
  output logic [Channels-1:0]   pulse_o,
  output logic [Channels-1:0]   event_o,
  output logic [Channels-1:0]   overrun_o
);

  for (genvar n = 0; n < Channels; n++) begin : g_chan
    edge_pulse_channel #(
      .SyncStages   (SyncStages),
      .FilterCycles (FilterCycles),
      .PulseWidth   (PulseWidth),
      .Retrigger    (Retrigger)
    ) u_chan (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .signal_i    (signal_i[n]),
      .edge_mode_i (edge_mode_t'(edge_mode_i[2*n +: 2])),
      .event_clr_i (event_clr_i[n]),
      .pulse_o     (pulse_o[n]),
      .event_o     (event_o[n]),
      .overrun_o   (overrun_o[n])
    );
  end

endmodule

// File: tb/tb_edge_pulse_array.sv
// ---------------------------------------------------------------------------
// tb_edge_pulse_array
// Four instances with different parameter sets share clock and reset:
//   0: defaults (4 ch)          1: FilterCycles=3, PulseWidth=5 (2 ch)
//   2: PulseWidth=5, no retrig  3: PulseWidth=8 (1 ch)
// A behavioural model predicts every output every cycle; directed table and
// hand-written sequences add checks against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_edge_pulse_array;
  import edge_sync_pkg::*;

  localparam int NI = 4;
  localparam int NCH [NI] = '{4, 2, 2, 1};
  localparam int SS  [NI] = '{2, 2, 2, 2};
  localparam int FCY [NI] = '{0, 3, 0, 0};
  localparam int PW  [NI] = '{1, 5, 5, 8};
  localparam int RT  [NI] = '{1, 1, 0, 1};

  logic clk_i = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [3:0] sig_v  [NI];
  logic [3:0] clr_v  [NI];
  logic [7:0] mode_v [NI];
  logic [3:0] pul_v  [NI];
  logic [3:0] ev_v   [NI];
  logic [3:0] ov_v   [NI];

  logic [3:0] pul_a, ev_a, ov_a;
  logic [1:0] pul_b, ev_b, ov_b;
  logic [1:0] pul_c, ev_c, ov_c;
  logic [0:0] pul_d, ev_d, ov_d;

  always_comb begin
    pul_v[0] = pul_a;          ev_v[0] = ev_a;          ov_v[0] = ov_a;
    pul_v[1] = {2'b00, pul_b}; ev_v[1] = {2'b00, ev_b}; ov_v[1] = {2'b00, ov_b};
    pul_v[2] = {2'b00, pul_c}; ev_v[2] = {2'b00, ev_c}; ov_v[2] = {2'b00, ov_c};
    pul_v[3] = {3'b000, pul_d}; ev_v[3] = {3'b000, ev_d}; ov_v[3] = {3'b000, ov_d};
  end

  edge_pulse_array #(.Channels(4)) u_a (
    .clk_i(clk_i), .reset_n_i(reset_n), .signal_i(sig_v[0]), .edge_mode_i(mode_v[0]),
    .event_clr_i(clr_v[0]), .pulse_o(pul_a), .event_o(ev_a), .overrun_o(ov_a));

  edge_pulse_array #(.Channels(2), .FilterCycles(3), .PulseWidth(5), .Retrigger(1)) u_b (
    .clk_i(clk_i), .reset_n_i(reset_n), .signal_i(sig_v[1][1:0]), .edge_mode_i(mode_v[1][3:0]),
    .event_clr_i(clr_v[1][1:0]), .pulse_o(pul_b), .event_o(ev_b), .overrun_o(ov_b));

  edge_pulse_array #(.Channels(2), .PulseWidth(5), .Retrigger(0)) u_c (
    .clk_i(clk_i), .reset_n_i(reset_n), .signal_i(sig_v[2][1:0]), .edge_mode_i(mode_v[2][3:0]),
    .event_clr_i(clr_v[2][1:0]), .pulse_o(pul_c), .event_o(ev_c), .overrun_o(ov_c));

  edge_pulse_array #(.Channels(1), .PulseWidth(8)) u_d (
    .clk_i(clk_i), .reset_n_i(reset_n), .signal_i(sig_v[3][0:0]), .edge_mode_i(mode_v[3][1:0]),
    .event_clr_i(clr_v[3][0:0]), .pulse_o(pul_d), .event_o(ev_d), .overrun_o(ov_d));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // hist holds the last SS raw samples (index 0 newest); run counts how long
  // the synchronised level has disagreed with the accepted level; rem is the
  // number of high cycles the pulse still has, counting the current one.
  int m_hist [NI][4][4];
  int m_f    [NI][4];
  int m_fd   [NI][4];
  int m_run  [NI][4];
  int m_rem  [NI][4];
  int m_ev   [NI][4];
  int m_ov   [NI][4];

  int hi_cnt   [NI][4];
  int rise_cnt [NI][4];
  int prev_pul [NI][4];

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      for (int ch = 0; ch < NCH[i]; ch++) begin
        int s;
        int qe;
        int ovs;
        int need;
        logic [1:0] md;
        if (!reset_n) begin
          for (int k = 0; k < 4; k++) m_hist[i][ch][k] = 0;
          m_f[i][ch] = 0; m_fd[i][ch] = 0; m_run[i][ch] = 0;
          m_rem[i][ch] = 0; m_ev[i][ch] = 0; m_ov[i][ch] = 0;
        end else begin
          s  = m_hist[i][ch][SS[i]-1];
          md = mode_v[i][2*ch +: 2];
          case (md)
            2'd0:    qe = (m_fd[i][ch] == 0 && m_f[i][ch] == 1) ? 1 : 0;
            2'd1:    qe = (m_fd[i][ch] == 1 && m_f[i][ch] == 0) ? 1 : 0;
            2'd2:    qe = (m_fd[i][ch] != m_f[i][ch]) ? 1 : 0;
            default: qe = 0;
          endcase
          ovs = (qe != 0 && m_rem[i][ch] > 0) ? 1 : 0;
          if (qe != 0) begin
            if (m_rem[i][ch] == 0 || RT[i] != 0) m_rem[i][ch] = PW[i];
            else m_rem[i][ch] = m_rem[i][ch] - 1;
          end else if (m_rem[i][ch] > 0) begin
            m_rem[i][ch] = m_rem[i][ch] - 1;
          end
          if (qe != 0) m_ev[i][ch] = 1;
          else if (clr_v[i][ch]) m_ev[i][ch] = 0;
          if (ovs != 0) m_ov[i][ch] = 1;
          else if (clr_v[i][ch]) m_ov[i][ch] = 0;
          m_fd[i][ch] = m_f[i][ch];
          need = (FCY[i] > 1) ? FCY[i] : 1;
          if (s != m_f[i][ch]) begin
            m_run[i][ch]++;
            if (m_run[i][ch] >= need) begin
              m_f[i][ch] = s;
              m_run[i][ch] = 0;
            end
          end else begin
            m_run[i][ch] = 0;
          end
          for (int k = 3; k > 0; k--) m_hist[i][ch][k] = m_hist[i][ch][k-1];
          m_hist[i][ch][0] = sig_v[i][ch] ? 1 : 0;
        end
      end
    end
  endtask

  // One clock: wait for the edge, sample 1 ns later, advance model, compare.
  task automatic tick();
    @(posedge clk_i);
    #1;
    model_step();
    for (int i = 0; i < NI; i++) begin
      for (int ch = 0; ch < NCH[i]; ch++) begin
        check($sformatf("model i%0d c%0d pulse", i, ch), pul_v[i][ch], m_rem[i][ch] > 0);
        check($sformatf("model i%0d c%0d event", i, ch), ev_v[i][ch], m_ev[i][ch] != 0);
        check($sformatf("model i%0d c%0d overrun", i, ch), ov_v[i][ch], m_ov[i][ch] != 0);
        if (pul_v[i][ch] === 1'b1) begin
          hi_cnt[i][ch]++;
          if (prev_pul[i][ch] == 0) rise_cnt[i][ch]++;
          prev_pul[i][ch] = 1;
        end else begin
          prev_pul[i][ch] = 0;
        end
      end
    end
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < NI; i++)
      for (int ch = 0; ch < 4; ch++) begin
        hi_cnt[i][ch] = 0;
        rise_cnt[i][ch] = 0;
      end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       sig;
    edge_mode_t mode;
    logic       clr;
    logic       pulse;
    logic       ev;
    logic       ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic s, input edge_mode_t m, input logic c,
                         input logic p, input logic e, input logic o);
    vec_t v;
    v.sig = s; v.mode = m; v.clr = c; v.pulse = p; v.ev = e; v.ov = o;
    tbl.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      sig_v[i] = '0; clr_v[i] = '0; mode_v[i] = '0;
      for (int ch = 0; ch < 4; ch++) begin
        prev_pul[i][ch] = 0; m_f[i][ch] = 0; m_fd[i][ch] = 0; m_run[i][ch] = 0;
        m_rem[i][ch] = 0; m_ev[i][ch] = 0; m_ov[i][ch] = 0;
        for (int k = 0; k < 4; k++) m_hist[i][ch][k] = 0;
      end
    end
    clear_cnt();

    // Channel 0 of instance 0 (defaults), one row per clock edge.
    // Rising: pulse after edge 4, one cycle wide; a falling edge is ignored.
    add_vec(1, EDGE_RISING, 0, 0, 0, 0);
    add_vec(1, EDGE_RISING, 0, 0, 0, 0);
    add_vec(1, EDGE_RISING, 0, 0, 0, 0);
    add_vec(1, EDGE_RISING, 0, 1, 1, 0);
    add_vec(1, EDGE_RISING, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) add_vec(0, EDGE_RISING, 0, 0, 1, 0);
    add_vec(0, EDGE_RISING, 1, 0, 0, 0);
    // Falling: the 0->1 is ignored, the 1->0 fires; clear with set loses.
    for (int k = 0; k < 4; k++) add_vec(1, EDGE_FALLING, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add_vec(0, EDGE_FALLING, 0, 0, 0, 0);
    add_vec(0, EDGE_FALLING, 1, 1, 1, 0);
    add_vec(0, EDGE_FALLING, 0, 0, 1, 0);
    add_vec(0, EDGE_FALLING, 1, 0, 0, 0);
    // Off: nothing in either direction.
    for (int k = 0; k < 5; k++) add_vec(1, EDGE_OFF, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) add_vec(0, EDGE_OFF, 0, 0, 0, 0);

    // Reset.
    reset_n = 1'b0;
    ticks(3);
    for (int i = 0; i < NI; i++)
      check($sformatf("reset i%0d outputs", i), {pul_v[i], ev_v[i], ov_v[i]}, 0);
    reset_n = 1'b1;
    tick();

    foreach (tbl[r]) begin
      sig_v[0][0]    = tbl[r].sig;
      mode_v[0][1:0] = tbl[r].mode;
      clr_v[0][0]    = tbl[r].clr;
      tick();
      check($sformatf("tbl%0d pulse", r), pul_v[0][0], tbl[r].pulse);
      check($sformatf("tbl%0d event", r), ev_v[0][0], tbl[r].ev);
      check($sformatf("tbl%0d overrun", r), ov_v[0][0], tbl[r].ov);
    end
    clr_v[0][0] = 1'b0;

    // Edges one cycle apart (FilterCycles=0, BOTH): six edges, one long pulse.
    mode_v[0][3:2] = EDGE_BOTH;
    clear_cnt();
    for (int k = 0; k < 6; k++) begin
      sig_v[0][1] = ~sig_v[0][1];
      tick();
    end
    ticks(8);
    check("toggle1 high cycles", hi_cnt[0][1], 6);
    check("toggle1 pulses", rise_cnt[0][1], 1);
    check("toggle1 overrun", ov_v[0][1], 1);

    // Glitch filter, FilterCycles=3, BOTH.
    mode_v[1] = {EDGE_BOTH, EDGE_BOTH};
    clear_cnt();
    sig_v[1][0] = 1'b1;
    ticks(2);
    sig_v[1][0] = 1'b0;
    ticks(12);
    check("glitch high cycles", hi_cnt[1][0], 0);
    check("glitch event", ev_v[1][0], 0);
    sig_v[1][0] = 1'b1;
    ticks(5);
    check("filter pulse at edge5", pul_v[1][0], 0);
    tick();
    check("filter pulse at edge6", pul_v[1][0], 1);
    ticks(8);
    check("filter rise high cycles", hi_cnt[1][0], 5);
    check("filter rise overrun", ov_v[1][0], 0);
    clear_cnt();
    sig_v[1][0] = 1'b0;
    ticks(15);
    check("filter fall high cycles", hi_cnt[1][0], 5);
    check("filter fall pulses", rise_cnt[1][0], 1);

    // Retrigger on, PulseWidth=5: edges 3 cycles apart, one continuous pulse.
    clear_cnt();
    sig_v[1][1] = 1'b1;
    ticks(3);
    sig_v[1][1] = 1'b0;
    ticks(3);
    sig_v[1][1] = 1'b1;
    ticks(25);
    check("retrig high cycles", hi_cnt[1][1], 11);
    check("retrig pulses", rise_cnt[1][1], 1);
    check("retrig overrun", ov_v[1][1], 1);

    // Retrigger off, PulseWidth=5: second edge two cycles in is ignored.
    mode_v[2][1:0] = EDGE_BOTH;
    clear_cnt();
    sig_v[2][0] = 1'b1;
    ticks(2);
    sig_v[2][0] = 1'b0;
    ticks(20);
    check("noretrig high cycles", hi_cnt[2][0], 5);
    check("noretrig pulses", rise_cnt[2][0], 1);
    check("noretrig overrun", ov_v[2][0], 1);

    // Reset mid-pulse, PulseWidth=8, input held high across release.
    mode_v[3][1:0] = EDGE_RISING;
    sig_v[3][0] = 1'b1;
    ticks(4);
    check("rst pulse cycle1", pul_v[3][0], 1);
    ticks(2);
    check("rst pulse cycle3", pul_v[3][0], 1);
    reset_n = 1'b0;
    tick();
    for (int i = 0; i < NI; i++)
      check($sformatf("midpulse reset i%0d outputs", i), {pul_v[i], ev_v[i], ov_v[i]}, 0);
    tick();
    reset_n = 1'b1;
    clear_cnt();
    ticks(3);
    check("release edge3 pulse", pul_v[3][0], 0);
    tick();
    check("release edge4 pulse", pul_v[3][0], 1);
    check("release edge4 event", ev_v[3][0], 1);
    ticks(10);
    check("release high cycles", hi_cnt[3][0], 8);
    check("release pulses", rise_cnt[3][0], 1);

    // Randomised traffic on every channel of every instance.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (c % 64 == 0) mode_v[i] = 8'($urandom());
        for (int ch = 0; ch < NCH[i]; ch++) begin
          if ($urandom_range(3) == 0) sig_v[i][ch] = ~sig_v[i][ch];
          clr_v[i][ch] = ($urandom_range(7) == 0);
        end
      end
      reset_n = ($urandom_range(499) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_pulse_array.md
# edge_pulse_array

Multi-channel, single-clock edge detector for asynchronous inputs such as buttons, external strobes and interrupt lines. Each channel synchronises its input and optionally deglitches it. It then detects the edge type selected at runtime and emits a pulse of programmable width. Each channel also keeps sticky event and overrun flags for register-mapped readout. The block sits between the pin level and the CPU-visible status/interrupt logic.

## Interface
- `Channels`, 4: number of independent channels, ≥1.
- `SyncStages`, 2: synchroniser flop depth, ≥2.
- `FilterCycles`, 0: consecutive stable cycles required before a level change is accepted; 0 means no filter.
- `PulseWidth`, 1: `pulse_o` high time in cycles, ≥1.
- `Retrigger`, 1: 1 means an edge during an active pulse restarts it; 0 means the edge is ignored.
- `clk_i`, input, 1: the single clock.
- `reset_n_i`, input, 1: synchronous, active-low reset.
- `signal_i`, input, `Channels`: asynchronous inputs.
- `edge_mode_i`, input, `2*Channels`: per-channel `edge_mode_t`; channel n uses bits [2n+1:2n]. Quasi-static.
- `event_clr_i`, input, `Channels`: per-channel clear of `event_o` and `overrun_o`.
- `pulse_o`, output, `Channels`: stretched pulse.
- `event_o`, output, `Channels`: sticky "qualified edge seen".
- `overrun_o`, output, `Channels`: sticky "qualified edge arrived while `pulse_o` was high".

## Operation
- **Per-channel pipeline:** sync chain → filter → level register `f` → previous-level register `f_d` → edge qualify → pulse counter.
- **Filter:** let `s` be the last sync stage.
  - If `s != f`, the counter `fc` increments.
  - When `s != f` and `fc == max(FilterCycles,1)-1`, then `f <= s` and `fc <= 0`.
  - If `s == f`, then `fc <= 0`.
  - With `FilterCycles=0`, `f` follows `s` with one cycle of delay.
  - A glitch shorter than `FilterCycles` cycles never reaches `f`.
- **Qualified edge (combinational)**, selected by mode:
  - RISING: `~f_d & f`
  - FALLING: `f_d & ~f`
  - BOTH: `f ^ f_d`
  - OFF: never
- **Mode changes:** `edge_mode_i` is evaluated in the same cycle as the edge. Changing the mode never cancels an active pulse.
- **Pulse, when idle:** a qualified edge sets `pulse_o <= 1` and `pc <= PulseWidth-1`.
- **Pulse, while active:** `pulse_o` stays high; when `pc == 0` it falls, otherwise `pc` decrements.
- **Qualified edge while `pulse_o` is high:**
  - `overrun_o` is set.
  - If `Retrigger=1`, `pc` reloads to `PulseWidth-1` and `pulse_o` stays high, including when `pc == 0`.
  - If `Retrigger=0`, the edge does not affect the pulse, and the pulse ends on schedule.
- **Sticky flags:** a qualified edge sets `event_o`. `event_clr_i` clears `event_o` and `overrun_o`. If set and clear happen in the same cycle, set wins.
- **Channel independence:** channels share nothing but `clk_i` and `reset_n_i`.

## Timing
- **Reset values:** while `reset_n_i=0` at a clock edge, every flop clears to 0: sync chain, `f`, `f_d`, `fc`, `pc`, `pulse_o`, `event_o`, `overrun_o`.
  - The outputs are therefore 0 from the first edge at which reset is sampled.
  - A reset mid-pulse truncates the pulse immediately.
- **Input high across reset release:** this is detected as a rising edge once it propagates through the pipeline.
- **Latency:** edge 1 is the first clock edge that samples the new level. `pulse_o`, `event_o` and `overrun_o` update at edge `SyncStages + max(FilterCycles,1) + 1`. With default parameters this is edge 4.
- **Pulse length:** `pulse_o` is high for exactly `PulseWidth` cycles per non-retriggered edge.
- **Minimum edge spacing:**
  - With `FilterCycles=0`, edges one cycle apart are all detected.
  - Otherwise, a level must be held for `FilterCycles` cycles to be seen.
- **Counter widths:**
  - `fc` is `max(1,$clog2(FilterCycles+1))` bits.
  - `pc` is `max(1,$clog2(PulseWidth))` bits.
  - Neither counter may wrap.

## Structure
- **Package `edge_sync_pkg`:** holds `typedef enum logic [1:0] edge_mode_t` with EDGE_RISING=0, EDGE_FALLING=1, EDGE_BOTH=2, EDGE_OFF=3.
- **Sub-module `edge_pulse_channel`:** one channel, with the same parameters minus `Channels`. The top level instantiates it `Channels` times in a generate loop and slices `edge_mode_i`.

## Test plan
- **Default latency, RISING mode, channel 0:** raise `signal_i[0]` just before an edge → `pulse_o[0]` is high for 1 cycle, rising after edge 4. `event_o[0]=1`; `overrun_o[0]=0`.
- **Glitch filter (`FilterCycles=3`, BOTH):** a 2-cycle glitch gives no pulse. A 3-cycle-held high gives a pulse after edge 6, and releasing it gives a second pulse.
- **Retrigger on (`PulseWidth=5`, BOTH):** toggle the input every 3 cycles, three times → continuous `pulse_o` from the first pulse until 5 cycles after the last edge's pulse start; `overrun_o=1`.
- **Retrigger off (`Retrigger=0`, `PulseWidth=5`):** a second edge 2 cycles into the pulse → total high time is 5 cycles and `overrun_o=1`.
- **Mode and flag control:** OFF mode produces no pulse or event. FALLING mode fires only on 1→0. Assert `event_clr_i` in the same cycle as a new edge → `event_o` stays 1; a clear in a later cycle → 0.
- **Reset mid-pulse (`PulseWidth=8`):** assert `reset_n_i=0` at pulse cycle 3 → all outputs are 0 at the next edge. With the input held high through reset release, one rising pulse appears 4 edges after release.
